// File: rtl/mem_load_queue.sv
`default_nettype none
// ==========================================================================
// mem_load_queue: DEPTH-entry in-order MEM stage between EX and WB with load
// alignment/extension and flush-safe data_ok discard. Option macro:
// MEM_LOAD_QUEUE_BYPASS_EN (same-cycle pass-through).  Revision: 1.0
// ==========================================================================
module mem_load_queue #(
  parameter int DEPTH     = 4,
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = 118
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_wait_data,
  input  logic [2:0]                  in_ld_op,
  input  logic [$clog2(DATA_W/8)-1:0] in_offset,
  input  logic                        in_res_from_mem,
  input  logic                        in_rf_we,
  input  logic [4:0]                  in_rf_waddr,
  input  logic [DATA_W-1:0]           in_result,
  input  logic [PAYLOAD_W-1:0]        in_payload,
  input  logic                        data_ok,
  input  logic [DATA_W-1:0]           rdata,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_rf_we,
  output logic [4:0]                  out_rf_waddr,
  output logic [DATA_W-1:0]           out_rf_wdata,
  output logic [DATA_W-1:0]           out_result,
  output logic [PAYLOAD_W-1:0]        out_payload,
  output logic                        fwd_load_busy,
  output logic [$clog2(DEPTH):0]      count,
  output logic [$clog2(DEPTH):0]      cancel_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(DATA_W/8);

  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [DEPTH-1:0]     wait_q, wait_d;
  logic [DEPTH-1:0]     filled_q, filled_d;
  logic [DEPTH-1:0]     rfm_q, rfm_d;
  logic [DEPTH-1:0]     rf_we_q, rf_we_d;
  logic [2:0]           ld_op_q    [DEPTH];
  logic [2:0]           ld_op_d    [DEPTH];
  logic [OW-1:0]        offset_q   [DEPTH];
  logic [OW-1:0]        offset_d   [DEPTH];
  logic [4:0]           rf_waddr_q [DEPTH];
  logic [4:0]           rf_waddr_d [DEPTH];
  logic [DATA_W-1:0]    result_q   [DEPTH];
  logic [DATA_W-1:0]    result_d   [DEPTH];
  logic [DATA_W-1:0]    data_q     [DEPTH];
  logic [DATA_W-1:0]    data_d     [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q  [DEPTH];
  logic [PAYLOAD_W-1:0] payload_d  [DEPTH];
  logic [AW-1:0]        head_q, head_d;
  logic [AW-1:0]        tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic [CW-1:0]        cancel_q, cancel_d;

  logic [DEPTH-1:0]     unfilled;
  logic [CW-1:0]        u_cnt;
  logic                 fill_hit;
  logic [AW-1:0]        fill_idx;
  logic [AW-1:0]        scan_idx;
  logic                 full;
  logic                 q_out_valid;
  logic                 byp_hit;
  logic                 byp_take;
  logic                 enq;
  logic                 pop;
  logic                 ok_cancel;
  logic                 ok_fill_old;
  logic                 ok_fill_new;
  logic                 flush_dec;
  logic                 head_live;

  function automatic logic [DATA_W-1:0] load_ext(
    input logic [DATA_W-1:0] data,
    input logic [2:0]        op,
    input logic [OW-1:0]     off
  );
    logic [DATA_W-1:0] sh;
    sh = data >> {off, 3'b000};
    case (op)
      3'b000:  load_ext = DATA_W'(signed'(sh[7:0]));
      3'b001:  load_ext = DATA_W'(sh[7:0]);
      3'b010:  load_ext = DATA_W'(signed'(sh[15:0]));
      3'b011:  load_ext = DATA_W'(sh[15:0]);
      3'b100:  load_ext = DATA_W'(signed'(sh[31:0]));
      3'b101:  load_ext = DATA_W'(sh[31:0]);
      default: load_ext = sh;
    endcase
  endfunction

  assign unfilled      = valid_q & wait_q & ~filled_q;
  assign fwd_load_busy = |(valid_q & rfm_q & ~filled_q);
  assign full          = (count_q == CW'(DEPTH));
  assign in_ready      = ~full & ~flush;
  assign q_out_valid   = valid_q[head_q] & filled_q[head_q] & ~flush;
  assign count         = count_q;
  assign cancel_cnt    = cancel_q;

`ifdef MEM_LOAD_QUEUE_BYPASS_EN
  assign byp_hit = ~reset & (count_q == '0) & ~flush & in_valid &
                   (~in_wait_data | (data_ok & (cancel_q == '0)));
`else
  assign byp_hit = 1'b0;
`endif

  assign byp_take    = byp_hit & out_ready;
  assign enq         = in_valid & in_ready & ~byp_take;
  assign pop         = q_out_valid & out_ready;
  assign ok_cancel   = data_ok & (cancel_q != '0);
  assign ok_fill_old = data_ok & ~ok_cancel & fill_hit;
  assign ok_fill_new = data_ok & ~ok_cancel & ~fill_hit & enq & in_wait_data;
  assign flush_dec   = data_ok & ((cancel_q != '0) | (u_cnt != '0));

  // Responses return in request order, so the oldest unfilled waiter owns data_ok.
  always_comb begin
    fill_hit = 1'b0;
    fill_idx = head_q;
    scan_idx = head_q;
    u_cnt    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      u_cnt    = u_cnt + CW'(unfilled[i]);
      scan_idx = head_q + AW'(i);
      if (!fill_hit && unfilled[scan_idx]) begin
        fill_hit = 1'b1;
        fill_idx = scan_idx;
      end
    end
  end

  always_comb begin
    valid_d    = valid_q;
    wait_d     = wait_q;
    filled_d   = filled_q;
    rfm_d      = rfm_q;
    rf_we_d    = rf_we_q;
    ld_op_d    = ld_op_q;
    offset_d   = offset_q;
    rf_waddr_d = rf_waddr_q;
    result_d   = result_q;
    data_d     = data_q;
    payload_d  = payload_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    cancel_d   = cancel_q;
    if (flush) begin
      // Every response still owed to a dropped load must be swallowed later.
      valid_d  = '0;
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      cancel_d = cancel_q + u_cnt - CW'(flush_dec);
    end else begin
      if (ok_cancel) begin
        cancel_d = cancel_q - CW'(1);
      end
      if (ok_fill_old) begin
        filled_d[fill_idx] = 1'b1;
        data_d[fill_idx]   = rdata;
      end
      if (enq) begin
        valid_d[tail_q]    = 1'b1;
        wait_d[tail_q]     = in_wait_data;
        filled_d[tail_q]   = ~in_wait_data | ok_fill_new;
        rfm_d[tail_q]      = in_res_from_mem;
        rf_we_d[tail_q]    = in_rf_we;
        ld_op_d[tail_q]    = in_ld_op;
        offset_d[tail_q]   = in_offset;
        rf_waddr_d[tail_q] = in_rf_waddr;
        result_d[tail_q]   = in_result;
        payload_d[tail_q]  = in_payload;
        if (ok_fill_new) begin
          data_d[tail_q] = rdata;
        end
        tail_d = tail_q + AW'(1);
      end
      if (pop) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + AW'(1);
      end
      count_d = count_q + CW'(enq) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      wait_q   <= '0;
      filled_q <= '0;
      rfm_q    <= '0;
      rf_we_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      cancel_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ld_op_q[i]    <= '0;
        offset_q[i]   <= '0;
        rf_waddr_q[i] <= '0;
        result_q[i]   <= '0;
        data_q[i]     <= '0;
        payload_q[i]  <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      wait_q     <= wait_d;
      filled_q   <= filled_d;
      rfm_q      <= rfm_d;
      rf_we_q    <= rf_we_d;
      ld_op_q    <= ld_op_d;
      offset_q   <= offset_d;
      rf_waddr_q <= rf_waddr_d;
      result_q   <= result_d;
      data_q     <= data_d;
      payload_q  <= payload_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      cancel_q   <= cancel_d;
    end
  end

  // Fields of an empty head read as zero so reset and drained states look clean.
  always_comb begin
    head_live    = valid_q[head_q];
    out_valid    = q_out_valid;
    out_rf_we    = q_out_valid & rf_we_q[head_q];
    out_rf_waddr = head_live ? rf_waddr_q[head_q] : '0;
    out_result   = head_live ? result_q[head_q] : '0;
    out_payload  = head_live ? payload_q[head_q] : '0;
    out_rf_wdata = '0;
    if (head_live) begin
      out_rf_wdata = rfm_q[head_q] ?
                     load_ext(data_q[head_q], ld_op_q[head_q], offset_q[head_q]) :
                     result_q[head_q];
    end
`ifdef MEM_LOAD_QUEUE_BYPASS_EN
    if (byp_hit) begin
      out_valid    = 1'b1;
      out_rf_we    = in_rf_we;
      out_rf_waddr = in_rf_waddr;
      out_result   = in_result;
      out_payload  = in_payload;
      out_rf_wdata = in_res_from_mem ? load_ext(rdata, in_ld_op, in_offset) : in_result;
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_load_queue.sv
`default_nettype none
// tb_mem_load_queue: directed tables plus randomized traffic checked against a
// queue-based reference model (DEPTH=4, DATA_W=32 and a DATA_W=64 instance).
module tb_mem_load_queue;

  typedef struct {
    bit v; bit wt; bit [2:0] op; bit [1:0] off; bit rfm; bit we; bit [4:0] wa;
    bit [31:0] res; bit dok; bit [31:0] rd; bit fl; bit ordy;
  } stim_t;
  typedef struct {
    bit wt; bit filled; bit [2:0] op; bit [1:0] off; bit rfm; bit we; bit [4:0] wa;
    bit [31:0] res; bit [117:0] pl; bit [31:0] data;
  } ent_t;
  typedef struct { bit [2:0] op; bit [1:0] off; bit [31:0] rd; bit [31:0] exp; } ld32_t;
  typedef struct { bit [2:0] op; bit [2:0] off; bit [63:0] rd; bit [63:0] exp; } ld64_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 0, in_wait_data = 0, in_res_from_mem = 0, in_rf_we = 0;
  logic [2:0]   in_ld_op = 0;
  logic [1:0]   in_offset = 0;
  logic [4:0]   in_rf_waddr = 0;
  logic [31:0]  in_result = 0, rdata = 0;
  logic [117:0] in_payload = 0;
  logic         data_ok = 0, flush = 0, out_ready = 1;
  logic         in_ready, out_valid, out_rf_we, fwd_load_busy;
  logic [4:0]   out_rf_waddr;
  logic [31:0]  out_rf_wdata, out_result;
  logic [117:0] out_payload;
  logic [2:0]   count, cancel_cnt;

  mem_load_queue #(.DEPTH(4), .DATA_W(32), .PAYLOAD_W(118)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_wait_data(in_wait_data), .in_ld_op(in_ld_op), .in_offset(in_offset),
    .in_res_from_mem(in_res_from_mem), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
    .in_result(in_result), .in_payload(in_payload), .data_ok(data_ok), .rdata(rdata),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_rf_we(out_rf_we),
    .out_rf_waddr(out_rf_waddr), .out_rf_wdata(out_rf_wdata), .out_result(out_result),
    .out_payload(out_payload), .fwd_load_busy(fwd_load_busy), .count(count),
    .cancel_cnt(cancel_cnt)
  );

  logic         b_in_valid = 0, b_wait = 0, b_rfm = 0, b_we = 0, b_dok = 0, b_fl = 0, b_ordy = 1;
  logic [2:0]   b_op = 0, b_off = 0;
  logic [4:0]   b_wa = 0;
  logic [63:0]  b_res = 0, b_rd = 0;
  logic [117:0] b_pl = 0;
  logic         b_in_ready, b_out_valid, b_out_we, b_busy;
  logic [4:0]   b_out_wa;
  logic [63:0]  b_out_wdata, b_out_res;
  logic [117:0] b_out_pl;
  logic [2:0]   b_count, b_cancel;

  mem_load_queue #(.DEPTH(4), .DATA_W(64), .PAYLOAD_W(118)) u_dut64 (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_wait_data(b_wait), .in_ld_op(b_op), .in_offset(b_off),
    .in_res_from_mem(b_rfm), .in_rf_we(b_we), .in_rf_waddr(b_wa),
    .in_result(b_res), .in_payload(b_pl), .data_ok(b_dok), .rdata(b_rd),
    .flush(b_fl), .out_valid(b_out_valid), .out_ready(b_ordy), .out_rf_we(b_out_we),
    .out_rf_waddr(b_out_wa), .out_rf_wdata(b_out_wdata), .out_result(b_out_res),
    .out_payload(b_out_pl), .fwd_load_busy(b_busy), .count(b_count),
    .cancel_cnt(b_cancel)
  );

  int n_chk = 0;
  int n_err = 0;
  ent_t mq[$];
  int m_cancel = 0;
  bit [117:0] cur_pl;
  logic obs_valid, obs_ready, obs_busy;
  logic [31:0] obs_wdata;
  logic [4:0] obs_waddr;
  logic [2:0] obs_count, obs_cancel;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic bit [63:0] lmask(input int n);
    return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  // Reference extension: pick the selected bytes, then sign/zero fill to width w.
  function automatic bit [63:0] ref_ext(input bit [63:0] d, input int w, input bit [2:0] op, input int off);
    bit [63:0] sh, r;
    int nb;
    bit sgn;
    sh = d >> (off * 8);
    case (op)
      3'd0: begin nb = 8;  sgn = 1; end
      3'd1: begin nb = 8;  sgn = 0; end
      3'd2: begin nb = 16; sgn = 1; end
      3'd3: begin nb = 16; sgn = 0; end
      3'd4: begin nb = 32; sgn = 1; end
      3'd5: begin nb = 32; sgn = 0; end
      default: begin nb = 64; sgn = 0; end
    endcase
    if (nb > w) nb = w;
    r = sh & lmask(nb);
    if (sgn && nb < w && sh[nb-1]) r = r | ~lmask(nb);
    return r & lmask(w);
  endfunction

  function automatic int model_u();
    int u = 0;
    foreach (mq[i]) if (mq[i].wt && !mq[i].filled) u++;
    return u;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    s.ordy = 1;
    return s;
  endfunction

  task automatic check_all(input stim_t s);
    int sz;
    bit ev, busy;
    sz = mq.size();
    ev = (sz > 0) && mq[0].filled && !s.fl;
    busy = 0;
    foreach (mq[i]) if (mq[i].rfm && !mq[i].filled) busy = 1;
    chk("in_ready", in_ready, (sz < 4) && !s.fl);
    chk("out_valid", out_valid, ev);
    chk("out_rf_we", out_rf_we, ev && mq[0].we);
    chk("count", count, sz);
    chk("cancel_cnt", cancel_cnt, m_cancel);
    chk("fwd_load_busy", fwd_load_busy, busy);
    if (sz == 0) begin
      chk("out_rf_waddr_empty", out_rf_waddr, 0);
      chk("out_result_empty", out_result, 0);
      chk("out_payload_empty", out_payload, 0);
      chk("out_rf_wdata_empty", out_rf_wdata, 0);
    end else begin
      chk("out_rf_waddr", out_rf_waddr, mq[0].wa);
      chk("out_result", out_result, mq[0].res);
      chk("out_payload", out_payload, mq[0].pl);
      if (ev)
        chk("out_rf_wdata", out_rf_wdata,
            mq[0].rfm ? ref_ext({32'b0, mq[0].data}, 32, mq[0].op, mq[0].off) : {32'b0, mq[0].res});
    end
  endtask

  task automatic model_update(input stim_t s);
    int sz, u;
    bit ev, enq, pop, newfill, found;
    ent_t e;
    sz = mq.size();
    if (s.fl) begin
      u = model_u();
      m_cancel = m_cancel + u - ((s.dok && (m_cancel > 0 || u > 0)) ? 1 : 0);
      mq.delete();
    end else begin
      ev = (sz > 0) && mq[0].filled;
      enq = s.v && (sz < 4);
      pop = ev && s.ordy;
      newfill = 0;
      if (s.dok) begin
        if (m_cancel > 0) m_cancel--;
        else begin
          found = 0;
          foreach (mq[i]) if (!found && mq[i].wt && !mq[i].filled) begin
            mq[i].filled = 1; mq[i].data = s.rd; found = 1;
          end
          if (!found && enq && s.wt) newfill = 1;
        end
      end
      if (pop) void'(mq.pop_front());
      if (enq) begin
        e.wt = s.wt; e.filled = !s.wt || newfill; e.op = s.op; e.off = s.off;
        e.rfm = s.rfm; e.we = s.we; e.wa = s.wa; e.res = s.res; e.pl = cur_pl;
        e.data = newfill ? s.rd : 32'd0;
        mq.push_back(e);
      end
    end
  endtask

  task automatic step(input stim_t s);
    logic [127:0] r;
    @(negedge clk);
    r = {$urandom, $urandom, $urandom, $urandom};
    cur_pl = r[117:0];
    in_payload = r[117:0];
    in_valid = s.v; in_wait_data = s.wt; in_ld_op = s.op; in_offset = s.off;
    in_res_from_mem = s.rfm; in_rf_we = s.we; in_rf_waddr = s.wa; in_result = s.res;
    data_ok = s.dok; rdata = s.rd; flush = s.fl; out_ready = s.ordy;
    #1;
    check_all(s);
    obs_valid = out_valid; obs_ready = in_ready; obs_busy = fwd_load_busy;
    obs_wdata = out_rf_wdata; obs_waddr = out_rf_waddr;
    obs_count = count; obs_cancel = cancel_cnt;
    model_update(s);
  endtask

  function automatic stim_t load(input bit [2:0] op, input bit [1:0] off, input bit [4:0] wa);
    stim_t s;
    s = idle();
    s.v = 1; s.wt = 1; s.rfm = 1; s.we = 1; s.op = op; s.off = off; s.wa = wa;
    s.res = 32'hA5A5_0000 | 32'(wa);
    return s;
  endfunction

  task automatic run64(input ld64_t t);
    @(negedge clk);
    b_in_valid = 1; b_wait = 1; b_rfm = 1; b_we = 1; b_op = t.op; b_off = t.off;
    b_wa = 5'd7; b_res = 64'h1111_2222_3333_4444;
    @(negedge clk);
    b_in_valid = 0; b_dok = 1; b_rd = t.rd;
    @(negedge clk);
    b_dok = 0;
    #1;
    chk("w64_out_valid", b_out_valid, 1);
    chk("w64_out_rf_wdata", b_out_wdata, t.exp);
    @(negedge clk);
    #1;
    chk("w64_count", b_count, 0);
  endtask

  ld32_t tab32[11];
  ld64_t tab64[7];

  initial begin
    stim_t s;
    tab32[0]  = '{3'd0, 2'd2, 32'h0080_0000, 32'hFFFF_FF80};
    tab32[1]  = '{3'd1, 2'd2, 32'h0080_0000, 32'h0000_0080};
    tab32[2]  = '{3'd2, 2'd2, 32'h8001_0000, 32'hFFFF_8001};
    tab32[3]  = '{3'd3, 2'd2, 32'h8001_0000, 32'h0000_8001};
    tab32[4]  = '{3'd0, 2'd3, 32'h7F00_0000, 32'h0000_007F};
    tab32[5]  = '{3'd2, 2'd0, 32'h0000_7FFF, 32'h0000_7FFF};
    tab32[6]  = '{3'd4, 2'd0, 32'h8000_0001, 32'h8000_0001};
    tab32[7]  = '{3'd5, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tab32[8]  = '{3'd6, 2'd0, 32'h1234_5678, 32'h1234_5678};
    tab32[9]  = '{3'd1, 2'd1, 32'h0000_FF00, 32'h0000_00FF};
    tab32[10] = '{3'd2, 2'd1, 32'h00FF_FE00, 32'hFFFF_FFFE};
    tab64[0] = '{3'd4, 3'd4, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001};
    tab64[1] = '{3'd5, 3'd4, 64'h8000_0001_0000_0000, 64'h0000_0000_8000_0001};
    tab64[2] = '{3'd6, 3'd0, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF};
    tab64[3] = '{3'd0, 3'd7, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80};
    tab64[4] = '{3'd3, 3'd6, 64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF};
    tab64[5] = '{3'd2, 3'd2, 64'h0000_0000_9ABC_0000, 64'hFFFF_FFFF_FFFF_9ABC};
    tab64[6] = '{3'd4, 3'd0, 64'h0000_0000_7FFF_FFFF, 64'h0000_0000_7FFF_FFFF};

    #3;
    check_all(idle());
    chk("w64_reset_count", b_count, 0);
    chk("w64_reset_valid", b_out_valid, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;

    foreach (tab64[i]) run64(tab64[i]);

    // ALU op: visible one cycle after enqueue, then pops.
    s = idle(); s.v = 1; s.we = 1; s.wa = 5'd3; s.res = 32'h1234_5678;
    step(s);
    chk("alu_ready", obs_ready, 1);
    step(idle());
    chk("alu_valid", obs_valid, 1);
    chk("alu_wdata", obs_wdata, 32'h1234_5678);
    step(idle());
    chk("alu_count_drained", obs_count, 0);

    foreach (tab32[i]) begin
      step(load(tab32[i].op, tab32[i].off, 5'(i + 1)));
      step(idle());
      s = idle(); s.dok = 1; s.rd = tab32[i].rd;
      step(s);
      step(idle());
      chk("ld32_valid", obs_valid, 1);
      chk("ld32_wdata", obs_wdata, tab32[i].exp);
      step(idle());
      chk("ld32_count", obs_count, 0);
    end

    // Fill to DEPTH, 5th offer refused, then drain in order.
    for (int i = 0; i < 4; i++) step(load(3'd4, 2'd0, 5'(i + 1)));
    s = idle(); s.v = 1; s.wa = 5'd30;
    step(s);
    chk("full_in_ready", obs_ready, 0);
    chk("full_busy", obs_busy, 1);
    chk("full_count", obs_count, 4);
    for (int i = 0; i < 5; i++) begin
      s = idle(); s.dok = (i < 4); s.rd = 32'h100 + 32'(i);
      step(s);
      if (i > 0) begin
        chk("drain_valid", obs_valid, 1);
        chk("drain_order", obs_waddr, 5'(i));
      end
    end
    step(idle());
    chk("drain_count", obs_count, 0);

    // Flush with 3 loads owed, then only the 4th response fills the new load.
    for (int i = 0; i < 3; i++) step(load(3'd4, 2'd0, 5'(i + 10)));
    s = idle(); s.fl = 1;
    step(s);
    chk("flush_in_ready", obs_ready, 0);
    step(load(3'd4, 2'd0, 5'd9));
    chk("flush_count", obs_count, 0);
    chk("flush_cancel", obs_cancel, 3);
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.dok = 1; s.rd = 32'hCAFE_0001 + 32'(i);
      step(s);
      chk("cancel_walk", obs_cancel, 3 - i);
      chk("cancel_no_valid", obs_valid, 0);
    end
    step(idle());
    chk("post_cancel_valid", obs_valid, 1);
    chk("post_cancel_wdata", obs_wdata, 32'hCAFE_0004);
    step(idle());

    // Asynchronous reset with 2 entries queued and one cancel owed.
    s = load(3'd4, 2'd0, 5'd20); s.ordy = 0;
    step(s);
    s = idle(); s.fl = 1; s.ordy = 0;
    step(s);
    s = load(3'd0, 2'd1, 5'd21); s.ordy = 0;
    step(s);
    s = idle(); s.v = 1; s.we = 1; s.wa = 5'd22; s.res = 32'h55; s.ordy = 0;
    step(s);
    s = idle(); s.ordy = 0;
    step(s);
    chk("pre_reset_count", obs_count, 2);
    chk("pre_reset_cancel", obs_cancel, 1);
    chk("pre_reset_busy", obs_busy, 1);
    @(negedge clk);
    in_valid = 0; data_ok = 0; flush = 0; out_ready = 1;
    #2;
    reset = 1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_cancel", cancel_cnt, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_rf_we", out_rf_we, 0);
    chk("rst_busy", fwd_load_busy, 0);
    chk("rst_waddr", out_rf_waddr, 0);
    chk("rst_wdata", out_rf_wdata, 0);
    chk("rst_result", out_result, 0);
    chk("rst_payload", out_payload, 0);
    mq.delete();
    m_cancel = 0;
    @(negedge clk);
    reset = 0;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      int outst;
      outst = m_cancel + model_u();
      s = idle();
      s.v    = ($urandom % 4) != 0;
      s.wt   = (($urandom % 2) == 1) && (outst < 4);
      s.rfm  = s.wt && (($urandom % 4) != 0);
      s.op   = 3'($urandom % 7);
      s.off  = 2'($urandom);
      s.we   = 1'($urandom);
      s.wa   = 5'($urandom);
      s.res  = $urandom;
      s.dok  = (($urandom % 3) == 0) && (outst > 0 || ($urandom % 4) == 0);
      s.rd   = $urandom;
      s.fl   = ($urandom % 40) == 0;
      s.ordy = ($urandom % 4) != 0;
      step(s);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
